// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: memory request/response, instruction-queue push and ROB redirect.
// master = the fetch unit, slave = memory controller / queue / ROB side.
interface inst_fetch_if;
    logic        mem_req_out;
    logic [31:0] mem_addr_out;
    logic        mem_rdy_in;
    logic [31:0] mem_inst_in;
    logic [31:0] inst_iq_out;
    logic [31:0] pc_iq_out;
    logic        rdy_inst_iq_out;
    logic        iq_full_in;
    logic        refresh_rob_cdb_in;
    logic [31:0] refresh_pc_rob_in;

    modport master (
        output mem_req_out, mem_addr_out, inst_iq_out, pc_iq_out, rdy_inst_iq_out,
        input  mem_rdy_in, mem_inst_in, iq_full_in, refresh_rob_cdb_in, refresh_pc_rob_in
    );

    modport slave (
        input  mem_req_out, mem_addr_out, inst_iq_out, pc_iq_out, rdy_inst_iq_out,
        output mem_rdy_in, mem_inst_in, iq_full_in, refresh_rob_cdb_in, refresh_pc_rob_in
    );
endinterface

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit feeding the instruction queue.
// Define JAL_PREDICT_EN to redirect next_pc on fetched JAL instructions.
//
// state    | meaning
// IDLE     | no request outstanding, may issue from pc
// WAIT_MEM | request outstanding, response will be pushed
// DISCARD  | request outstanding after a flush, response will be dropped
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    inst_fetch_if.master bus
);

    typedef enum logic [1:0] {IDLE, WAIT_MEM, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_iq_q, pc_iq_d;
    logic        req_q, req_d;
    logic        push_q, push_d;
    logic [31:0] next_pc;

`ifdef JAL_PREDICT_EN
    logic [31:0] jal_imm;

    assign jal_imm = {{12{bus.mem_inst_in[31]}}, bus.mem_inst_in[19:12], bus.mem_inst_in[20],
                      bus.mem_inst_in[30:21], 1'b0};

    always_comb begin
        next_pc = pc_q + 32'd4;
        if (bus.mem_inst_in[6:0] == 7'b1101111) begin
            next_pc = pc_q + jal_imm;
        end
    end
`else
    // Mispredicted JALs are corrected by the ROB through a refresh.
    assign next_pc = pc_q + 32'd4;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                IDLE: begin
                    if (!bus.refresh_rob_cdb_in && !bus.iq_full_in) begin
                        state_d = WAIT_MEM;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rdy_in) begin
                        state_d = IDLE;
                    end else if (bus.refresh_rob_cdb_in) begin
                        state_d = DISCARD;
                    end
                end
                DISCARD: begin
                    if (bus.mem_rdy_in) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        inst_d  = inst_q;
        pc_iq_d = pc_iq_q;
        push_d  = push_q;
        if (rdy_in) begin
            push_d = 1'b0;
            // A redirect always wins the pc; a response arriving with it is dropped.
            if (bus.refresh_rob_cdb_in) begin
                pc_d = bus.refresh_pc_rob_in;
            end
            case (state_q)
                IDLE: begin
                    if (!bus.refresh_rob_cdb_in && !bus.iq_full_in) begin
                        req_d  = 1'b1;
                        addr_d = pc_q;
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rdy_in) begin
                        req_d = 1'b0;
                        if (!bus.refresh_rob_cdb_in) begin
                            inst_d  = bus.mem_inst_in;
                            pc_iq_d = pc_q;
                            push_d  = 1'b1;
                            pc_d    = next_pc;
                        end
                    end
                end
                DISCARD: begin
                    if (bus.mem_rdy_in) begin
                        req_d = 1'b0;
                    end
                end
                default: req_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q    <= RESET_PC;
            addr_q  <= 32'h0;
            req_q   <= 1'b0;
            inst_q  <= 32'h0;
            pc_iq_q <= 32'h0;
            push_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            inst_q  <= inst_d;
            pc_iq_q <= pc_iq_d;
            push_q  <= push_d;
        end
    end

    assign bus.mem_req_out     = req_q;
    assign bus.mem_addr_out    = addr_q;
    assign bus.inst_iq_out     = inst_q;
    assign bus.pc_iq_out       = pc_iq_q;
    assign bus.rdy_inst_iq_out = push_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a latency-programmable memory model plus
// request/push scoreboards; build with JAL_PREDICT_EN to check the predicted JAL path.
module tb_inst_fetch;

    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    inst_fetch_if fif ();

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (fif)
    );

    always #5 clk_in = ~clk_in;

`ifdef JAL_PREDICT_EN
    localparam logic [31:0] JAL_NEXT = 32'h0000_0110;
`else
    localparam logic [31:0] JAL_NEXT = 32'h0000_0104;
`endif

    typedef struct {
        int          lat;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } push_t;

    logic [31:0] exp_req[$];
    push_t       exp_push[$];
    vec_t        vecs[4];

    int          checks = 0;
    int          errors = 0;
    int          n_req = 0;
    int          n_push = 0;
    int          mem_lat = 3;
    int          mem_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    function automatic logic [31:0] mem_func(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'h0100_006F;
        return {a[24:0], 7'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_ev(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] inst);
        push_t e;
        e.pc   = pc;
        e.inst = inst;
        exp_push.push_back(e);
    endtask

    // One clock: monitor the scoreboards after the edge, then step the memory model.
    task automatic tick();
        logic  rdy_e;
        logic  rose;
        push_t e;
        rdy_e = rdy_in;
        @(posedge clk_in);
        #1;
        rose = fif.mem_req_out && !prev_req;
        if (fif.rdy_inst_iq_out && rdy_e) begin
            n_push++;
            if (exp_push.size() == 0) begin
                fail_ev("unexpected_push");
            end else begin
                e = exp_push.pop_front();
                check("push_pc", fif.pc_iq_out, e.pc);
                check("push_inst", fif.inst_iq_out, e.inst);
            end
        end
        if (rdy_e && prev_strobe) check("strobe_width", fif.rdy_inst_iq_out, 1'b0);
        if (rose) begin
            n_req++;
            if (exp_req.size() == 0) fail_ev("unexpected_req");
            else check("req_addr", fif.mem_addr_out, exp_req.pop_front());
        end
        if (prev_req && fif.mem_req_out) check("addr_stable", fif.mem_addr_out, prev_addr);
        prev_req    = fif.mem_req_out;
        prev_addr   = fif.mem_addr_out;
        prev_strobe = fif.rdy_inst_iq_out;

        fif.mem_rdy_in = 1'b0;
        if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                fif.mem_rdy_in  = 1'b1;
                fif.mem_inst_in = mem_func(fif.mem_addr_out);
            end
        end
        if (rose) begin
            if (mem_lat <= 1) begin
                fif.mem_rdy_in  = 1'b1;
                fif.mem_inst_in = mem_func(fif.mem_addr_out);
            end else begin
                mem_cnt = mem_lat - 1;
            end
        end
        if (rst_in) begin
            mem_cnt        = 0;
            fif.mem_rdy_in = 1'b0;
        end
    endtask

    task automatic wait_req();
        int tgt;
        tgt = n_req + 1;
        for (int k = 0; k < 100 && n_req < tgt; k++) tick();
        if (n_req < tgt) fail_ev("req_timeout");
    endtask

    task automatic wait_push();
        int tgt;
        tgt = n_push + 1;
        for (int k = 0; k < 100 && n_push < tgt; k++) tick();
        if (n_push < tgt) fail_ev("push_timeout");
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req"}, fif.mem_req_out, 1'b0);
        check({tag, "_addr"}, fif.mem_addr_out, 32'h0);
        check({tag, "_strobe"}, fif.rdy_inst_iq_out, 1'b0);
        check({tag, "_inst"}, fif.inst_iq_out, 32'h0);
        check({tag, "_pc_iq"}, fif.pc_iq_out, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3, 32'h0000_0000, mem_func(32'h0000_0000)};
        vecs[1] = '{3, 32'h0000_0004, mem_func(32'h0000_0004)};
        vecs[2] = '{3, 32'h0000_0008, mem_func(32'h0000_0008)};
        vecs[3] = '{1, 32'h0000_000C, mem_func(32'h0000_000C)};

        rst_in                 = 1'b1;
        rdy_in                 = 1'b1;
        fif.iq_full_in         = 1'b0;
        fif.refresh_rob_cdb_in = 1'b1;
        fif.refresh_pc_rob_in  = 32'h0000_0040;
        fif.mem_rdy_in         = 1'b0;
        fif.mem_inst_in        = 32'h0;
        tick();
        tick();
        check_zero("reset");
        fif.refresh_rob_cdb_in = 1'b0;
        rst_in                 = 1'b0;

        // Main stream from RESET_PC with varying memory latency.
        for (int i = 0; i < 4; i++) begin
            mem_lat = vecs[i].lat;
            exp_req.push_back(vecs[i].exp_pc);
            push_exp(vecs[i].exp_pc, vecs[i].exp_inst);
            wait_push();
        end

        // Queue fills while 0x10 is in flight: response still pushed, no new issue.
        mem_lat = 4;
        exp_req.push_back(32'h0000_0010);
        push_exp(32'h0000_0010, mem_func(32'h0000_0010));
        wait_req();
        fif.iq_full_in = 1'b1;
        wait_push();
        tick();
        tick();
        tick();
        check("iq_full_no_req", fif.mem_req_out, 1'b0);

        // Refresh in IDLE blocks the issue that cycle even with the queue free.
        fif.iq_full_in         = 1'b0;
        fif.refresh_rob_cdb_in = 1'b1;
        fif.refresh_pc_rob_in  = 32'h0000_0020;
        tick();
        fif.refresh_rob_cdb_in = 1'b0;
        check("idle_refresh_no_req", fif.mem_req_out, 1'b0);
        mem_lat = 3;
        exp_req.push_back(32'h0000_0020);
        wait_req();

        // Flush one cycle after issuing 0x20: response discarded, restart at 0x200.
        fif.refresh_rob_cdb_in = 1'b1;
        fif.refresh_pc_rob_in  = 32'h0000_0200;
        tick();
        fif.refresh_rob_cdb_in = 1'b0;
        check("discard_req_held", fif.mem_req_out, 1'b1);
        check("discard_addr_held", fif.mem_addr_out, 32'h0000_0020);
        exp_req.push_back(32'h0000_0200);
        push_exp(32'h0000_0200, mem_func(32'h0000_0200));
        wait_push();

        // Flush on the same edge as the response.
        exp_req.push_back(32'h0000_0204);
        wait_req();
        for (int k = 0; k < 20 && !fif.mem_rdy_in; k++) tick();
        if (!fif.mem_rdy_in) fail_ev("mem_rdy_timeout");
        fif.refresh_rob_cdb_in = 1'b1;
        fif.refresh_pc_rob_in  = 32'h0000_0080;
        tick();
        fif.refresh_rob_cdb_in = 1'b0;
        check("coincide_no_push", fif.rdy_inst_iq_out, 1'b0);
        check("coincide_req_drop", fif.mem_req_out, 1'b0);
        exp_req.push_back(32'h0000_0080);
        push_exp(32'h0000_0080, mem_func(32'h0000_0080));
        wait_push();

        // PC wrap-around at the top of the address space.
        fif.refresh_rob_cdb_in = 1'b1;
        fif.refresh_pc_rob_in  = 32'hFFFF_FFFC;
        tick();
        fif.refresh_rob_cdb_in = 1'b0;
        exp_req.push_back(32'hFFFF_FFFC);
        push_exp(32'hFFFF_FFFC, mem_func(32'hFFFF_FFFC));
        wait_push();
        exp_req.push_back(32'h0000_0000);
        push_exp(32'h0000_0000, mem_func(32'h0000_0000));
        wait_push();

        // JAL at 0x100.
        fif.refresh_rob_cdb_in = 1'b1;
        fif.refresh_pc_rob_in  = 32'h0000_0100;
        tick();
        fif.refresh_rob_cdb_in = 1'b0;
        exp_req.push_back(32'h0000_0100);
        push_exp(32'h0000_0100, 32'h0100_006F);
        wait_push();
        exp_req.push_back(JAL_NEXT);
        push_exp(JAL_NEXT, mem_func(JAL_NEXT));
        wait_push();

        // Stall with the strobe high: everything holds, strobe drops on the first enabled edge.
        rdy_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_strobe", fif.rdy_inst_iq_out, 1'b1);
            check("stall_pc_iq", fif.pc_iq_out, JAL_NEXT);
            check("stall_inst", fif.inst_iq_out, mem_func(JAL_NEXT));
            check("stall_req", fif.mem_req_out, 1'b0);
        end
        exp_req.push_back(JAL_NEXT + 32'd4);
        rdy_in = 1'b1;
        tick();
        check("stall_strobe_clear", fif.rdy_inst_iq_out, 1'b0);

        // Asynchronous reset with a request outstanding.
        tick();
        rst_in = 1'b1;
        #1;
        check_zero("async_reset");
        tick();
        tick();
        exp_req.push_back(32'h0000_0000);
        push_exp(32'h0000_0000, mem_func(32'h0000_0000));
        rst_in = 1'b0;
        wait_push();

        check("req_queue_empty", exp_req.size(), 32'd0);
        check("push_queue_empty", exp_push.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded at reset.
REQ-002 SHALL have port clk_in  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port rdy_in  input  1  global enable; when low, all state holds.
REQ-005 SHALL have port mem_req_out  output  1  fetch request to memory controller.
REQ-006 SHALL have port mem_addr_out  output  32  fetch byte address.
REQ-007 SHALL have port mem_rdy_in  input  1  one-cycle pulse; mem_inst_in valid.
REQ-008 SHALL have port mem_inst_in  input  32  fetched instruction word.
REQ-009 SHALL have port inst_iq_out  output  32  instruction pushed to instruction queue.
REQ-010 SHALL have port pc_iq_out  output  32  PC of inst_iq_out.
REQ-011 SHALL have port rdy_inst_iq_out  output  1  push strobe to instruction queue.
REQ-012 SHALL have port iq_full_in  input  1  queue full; no new fetch may start.
REQ-013 SHALL have port refresh_rob_cdb_in  input  1  pipeline flush (mispredict).
REQ-014 SHALL have port refresh_pc_rob_in  input  32  redirect PC, valid with refresh.

Function
REQ-015 SHALL implement states IDLE, WAIT_MEM, DISCARD; at most one request outstanding.
REQ-016 IDLE, rdy_in, !iq_full_in, !refresh: SHALL register mem_req_out=1 and mem_addr_out=pc, then go to WAIT_MEM.
REQ-017 WAIT_MEM: mem_req_out and mem_addr_out SHALL be held stable until the mem_rdy_in edge, then mem_req_out=0.
REQ-018 WAIT_MEM, mem_rdy_in, !refresh: SHALL register inst_iq_out=mem_inst_in, pc_iq_out=pc, rdy_inst_iq_out=1, pc=next_pc, and go to IDLE.
REQ-019 rdy_inst_iq_out SHALL be high for exactly one rdy_in-qualified edge; it clears on the next edge with rdy_in high.
REQ-020 Memory-response-to-push latency SHALL be 1 cycle; back-to-back fetch issue interval SHALL be 1 idle cycle minimum.
REQ-021 Refresh in IDLE: SHALL set pc=refresh_pc_rob_in, with no request issued that cycle.
REQ-022 Refresh in WAIT_MEM without mem_rdy_in: SHALL set pc=refresh_pc_rob_in and go to DISCARD, keeping mem_req_out asserted.
REQ-023 Refresh coinciding with mem_rdy_in: SHALL drop the data, set pc=refresh_pc_rob_in, and go to IDLE.
REQ-024 DISCARD: on mem_rdy_in, SHALL drop the data, clear mem_req_out, and go to IDLE; a further refresh SHALL update pc only.
REQ-025 Refresh SHALL clear rdy_inst_iq_out on the same edge.
REQ-026 iq_full_in SHALL gate only new issues; an in-flight response SHALL still be pushed (the queue reserves two slots).
REQ-027 Default next_pc SHALL be pc+4, using 32-bit arithmetic with wrap-around from 32'hFFFF_FFFC to 0.

Reset
REQ-028 rst_in high SHALL asynchronously force state=IDLE, pc=RESET_PC, and all outputs to 0, overriding rdy_in and refresh.
REQ-029 Reset mid-WAIT_MEM SHALL abandon the request; the memory controller is reset by the same rst_in.

Configuration
REQ-030 Macro JAL_PREDICT_EN defined: if mem_inst_in[6:0]==7'b1101111, next_pc SHALL be pc+sign-extended J-immediate, else pc+4.
REQ-031 Macro JAL_PREDICT_EN undefined: next_pc SHALL always be pc+4, and JAL SHALL be corrected via refresh.

Verification
REQ-032 Reset with RESET_PC=0, iq_full_in=0, memory latency 3 -> requests at 0,4,8; pushes carry pc 0,4,8, each rdy_inst_iq_out one cycle wide.
REQ-033 iq_full_in=1 while in WAIT_MEM at pc=0x10 -> the response is pushed with pc 0x10, and no request is issued until iq_full_in falls.
REQ-034 Refresh to 0x200 one cycle after issuing 0x20 -> mem_addr_out stays 0x20 until mem_rdy_in, no push occurs, and the next request is 0x200.
REQ-035 Refresh to 0x80 on the same edge as mem_rdy_in -> no push, and the next request is 0x80.
REQ-036 Fetch at 0x100 of 32'h0100006F (jal x0,+16) -> next request 0x110 with JAL_PREDICT_EN, 0x104 without.
REQ-037 rdy_in held low for 5 cycles while rdy_inst_iq_out=1 -> all outputs hold, and the strobe clears on the first edge with rdy_in high.
